// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back and drives datapath controls.
// Latency: 2-5 state cycles per instruction with memReady high; outputs are combinational from state and latched opcode.
// Backpressure: FETCH, MEMRD and MEMWR hold (strobes steady) until memReady; each low cycle adds exactly one cycle.
module mc_main_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        memReady,
   output logic        pcWrite,
   output logic        pcWriteCond,
   output logic        branchNe,
   output logic        iorD,
   output logic        memRead,
   output logic        memWrite,
   output logic        irWrite,
   output logic        memToReg,
   output logic        regDst,
   output logic        regWrite,
   output logic        aluSrcA,
   output logic [1:0]  aluSrcB,
   output logic [1:0]  aluOp,
   output logic [1:0]  pcSource,
   output logic [3:0]  state,
   output logic        illegal,
   output logic [31:0] instrCount
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;

   state_t      cur;
   state_t      nxt;
   state_t      dec;        // state used for output decode; forced to FETCH during reset
   logic [5:0]  opReg;
   logic [31:0] cnt;
   logic        opLegal;
   logic        retire;

   // Opcode legality and next-state selection
   always_comb begin
      opLegal = 1'b1;
      nxt     = S_FETCH;
      case (cur)
         S_FETCH:  nxt = memReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:        nxt = S_EXEC;
               OP_LW, OP_SW:    nxt = S_MEMADR;
               OP_BEQ, OP_BNE:  nxt = S_BRANCH;
               OP_J:            nxt = S_JUMP;
               OP_ADDI, OP_ANDI: nxt = S_IEXEC;
               default: begin
                  opLegal = 1'b0;
                  nxt     = S_FETCH;
               end
            endcase
         end
         S_MEMADR: nxt = (opReg == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  nxt = memReady ? S_MEMWB : S_MEMRD;
         S_MEMWR:  nxt = memReady ? S_FETCH : S_MEMWR;
         S_EXEC:   nxt = S_ALUWB;
         S_IEXEC:  nxt = S_IWB;
         default:  nxt = S_FETCH;
      endcase
   end

   // Last cycle of a legal instruction; a store only retires on its committing cycle
   always_comb begin
      retire = 1'b0;
      case (cur)
         S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IWB: retire = 1'b1;
         S_MEMWR: retire = memReady;
         default: retire = 1'b0;
      endcase
   end

   // State register, opcode latch and retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset) begin
         cur   <= S_FETCH;
         opReg <= 6'd0;
         cnt   <= 32'd0;
      end else begin
         cur <= nxt;
         if (cur == S_DECODE)
            opReg <= opcode;
         if (retire)
            cnt <= cnt + 32'd1;
      end
   end

   // Datapath controls decoded from state and latched opcode
   always_comb begin
      dec         = reset ? S_FETCH : cur;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      branchNe    = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      memToReg    = 1'b0;
      regDst      = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
      pcSource    = 2'b00;
      illegal     = 1'b0;
      case (dec)
         S_FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'b01;
            irWrite = memReady;
            pcWrite = memReady;
         end
         S_DECODE: begin
            aluSrcB = 2'b11;
            illegal = ~opLegal;
         end
         S_MEMADR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
         end
         S_MEMRD: begin
            memRead = 1'b1;
            iorD    = 1'b1;
         end
         S_MEMWB: begin
            regWrite = 1'b1;
            memToReg = 1'b1;
         end
         S_MEMWR: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
         end
         S_EXEC: begin
            aluSrcA = 1'b1;
            aluOp   = 2'b10;
         end
         S_ALUWB: begin
            regWrite = 1'b1;
            regDst   = 1'b1;
         end
         S_BRANCH: begin
            aluSrcA     = 1'b1;
            aluOp       = 2'b01;
            pcWriteCond = 1'b1;
            pcSource    = 2'b01;
            branchNe    = (opReg == OP_BNE);
         end
         S_JUMP: begin
            pcWrite  = 1'b1;
            pcSource = 2'b10;
         end
         S_IEXEC: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            aluOp   = (opReg == OP_ANDI) ? 2'b11 : 2'b00;
         end
         S_IWB: begin
            regWrite = 1'b1;
         end
         default: ;
      endcase
   end

   assign state      = cur;
   assign instrCount = cnt;

endmodule
